// File: rtl/eth_rx_pkg.sv
// rtl/eth_rx_pkg.sv - shared states, constants and helpers for the Ethernet RX frame parser
package eth_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DST_MAC,
    ST_SRC_MAC,
    ST_ETHERTYPE,
    ST_PAYLOAD,
    ST_DROP
  } rx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

  localparam int MAC_BYTES   = 6;
  localparam int ETYPE_BYTES = 2;
  localparam int FCS_BYTES   = 4;

  // Bit-reverse a 32-bit word (converts between normal and reflected CRC forms)
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - byte-wide reflected CRC-32 register with clear and enable
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

  logic [31:0] crc_q;

  // Next CRC for one byte, data bits consumed LSB first
  always_comb begin : next_crc
    logic [31:0] c;
    c = crc_q;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ POLY_R;
      end else begin
        c = c >> 1;
      end
    end
    crc_next = c;
  end

  // CRC state: clear to all-ones at frame start, advance on each enabled byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 32'hFFFF_FFFF;
    end else if (clr) begin
      crc_q <= 32'hFFFF_FFFF;
    end else if (en) begin
      crc_q <= crc_next;
    end
  end

endmodule

// File: rtl/eth_rx_frame_parser.sv
// rtl/eth_rx_frame_parser.sv - GMII RX parser: preamble strip, MAC filter, payload framing; FCS check under ETH_RX_FCS_CHECK_EN
module eth_rx_frame_parser
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
  parameter int          MAX_PREAMBLE = 7,
  parameter int          MIN_PAYLOAD  = 46
) (
  input  logic        clk250In,
  input  logic        rstNIn,
  input  logic [7:0]  rxDataIn,
  input  logic        rxDataValidIn,
  input  logic        rxDataLastIn,
  output logic [7:0]  payloadOut,
  output logic        payloadValidOut,
  output logic        payloadStartOut,
  output logic        payloadLastOut,
  output logic [15:0] etherTypeOut,
  output logic [47:0] srcMacOut,
  output logic        frameDropOut,
  output logic [15:0] frameCntOut
);

  localparam logic [3:0]  MAC_LAST   = 4'(MAC_BYTES - 1);
  localparam logic [3:0]  ETYPE_LAST = 4'(ETYPE_BYTES - 1);
  localparam logic [3:0]  PRE_MAX    = 4'(MAX_PREAMBLE);
  localparam logic [10:0] PAY_SAT    = 11'h7FF;

  rx_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [47:0] mac_sr_q, mac_sr_d;
  logic [7:0]  type_hi_q, type_hi_d;
  logic [10:0] pay_cnt_q, pay_cnt_d;
  logic [7:0]  payload_q, payload_d;
  logic        pvalid_q, pvalid_d;
  logic        pstart_q, pstart_d;
  logic        plast_q, plast_d;
  logic [15:0] etype_q, etype_d;
  logic [47:0] src_q, src_d;
  logic        drop_q, drop_d;
  logic        accept_q, accept_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [47:0] dst_next;
  logic        bad_end;

  assign dst_next = {mac_sr_q[39:0], rxDataIn};

`ifdef ETH_RX_FCS_CHECK_EN
  logic [3:0][7:0] dly_q, dly_d;
  logic            crc_clr, crc_en;
  logic [31:0]     crc_next;

  // CRC restarts on every pre-header byte so the SFD leaves it at all-ones
  assign crc_clr = rxDataValidIn && (state_q == ST_IDLE || state_q == ST_PREAMBLE);
  assign crc_en  = rxDataValidIn &&
                   (state_q inside {ST_DST_MAC, ST_SRC_MAC, ST_ETHERTYPE, ST_PAYLOAD});

  crc32_d8 u_crc (
    .clk      (clk250In),
    .rst_n    (rstNIn),
    .clr      (crc_clr),
    .en       (crc_en),
    .data     (rxDataIn),
    .crc_next (crc_next)
  );

  // Four-byte delay line that holds back the trailing FCS
  always_ff @(posedge clk250In or negedge rstNIn) begin
    if (!rstNIn) begin
      dly_q <= '0;
    end else begin
      dly_q <= dly_d;
    end
  end
`endif

  // Next-state and next-output logic; everything advances only on valid bytes
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mac_sr_d    = mac_sr_q;
    type_hi_d   = type_hi_q;
    pay_cnt_d   = pay_cnt_q;
    payload_d   = payload_q;
    pvalid_d    = 1'b0;
    pstart_d    = 1'b0;
    plast_d     = 1'b0;
    etype_d     = etype_q;
    src_d       = src_q;
    drop_d      = 1'b0;
    accept_d    = 1'b0;
    bad_end     = 1'b0;
    frame_cnt_d = accept_q ? frame_cnt_q + 16'd1 : frame_cnt_q;
`ifdef ETH_RX_FCS_CHECK_EN
    dly_d       = dly_q;
`endif
    if (rxDataValidIn) begin
      case (state_q)
        ST_IDLE: begin
          if (rxDataIn == ETH_PREAMBLE) begin
            state_d = ST_PREAMBLE;
            cnt_d   = 4'd1;
          end else if (rxDataIn == ETH_SFD) begin
            state_d = ST_DST_MAC;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_DROP;
          end
        end
        ST_PREAMBLE: begin
          if (rxDataIn == ETH_PREAMBLE && cnt_q < PRE_MAX) begin
            cnt_d = cnt_q + 4'd1;
          end else if (rxDataIn == ETH_SFD) begin
            state_d = ST_DST_MAC;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_DROP;
          end
        end
        ST_DST_MAC: begin
          mac_sr_d = dst_next;
          if (cnt_q == MAC_LAST) begin
            cnt_d   = 4'd0;
            state_d = (dst_next == LOCAL_MAC || dst_next == BCAST_MAC) ? ST_SRC_MAC : ST_DROP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_SRC_MAC: begin
          mac_sr_d = dst_next;
          if (cnt_q == MAC_LAST) begin
            cnt_d   = 4'd0;
            state_d = ST_ETHERTYPE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_ETHERTYPE: begin
          if (cnt_q == ETYPE_LAST) begin
            etype_d   = {type_hi_q, rxDataIn};
            src_d     = mac_sr_q;
            pay_cnt_d = 11'd0;
            state_d   = ST_PAYLOAD;
          end else begin
            type_hi_d = rxDataIn;
            cnt_d     = cnt_q + 4'd1;
          end
        end
        ST_PAYLOAD: begin
          if (pay_cnt_q != PAY_SAT) begin
            pay_cnt_d = pay_cnt_q + 11'd1;
          end
`ifdef ETH_RX_FCS_CHECK_EN
          dly_d = {dly_q[2:0], rxDataIn};
          if (pay_cnt_q >= 11'(FCS_BYTES)) begin
            payload_d = dly_q[3];
            pvalid_d  = 1'b1;
            pstart_d  = (pay_cnt_q == 11'(FCS_BYTES));
            plast_d   = rxDataLastIn;
          end
          bad_end = (int'(pay_cnt_q) + 1 < MIN_PAYLOAD + FCS_BYTES) ||
                    (reflect32(crc_next) != CRC32_RESIDUE);
`else
          payload_d = rxDataIn;
          pvalid_d  = 1'b1;
          pstart_d  = (pay_cnt_q == 11'd0);
          plast_d   = rxDataLastIn;
          bad_end   = (int'(pay_cnt_q) + 1 < MIN_PAYLOAD);
`endif
          if (rxDataLastIn) begin
            state_d  = ST_IDLE;
            drop_d   = bad_end;
            accept_d = !bad_end;
          end
        end
        ST_DROP: begin
          if (rxDataLastIn) begin
            state_d = ST_IDLE;
            drop_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // A frame that ends before its payload is incomplete and is discarded
      if (rxDataLastIn && state_q != ST_PAYLOAD && state_q != ST_DROP) begin
        state_d = ST_IDLE;
        drop_d  = 1'b1;
      end
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk250In or negedge rstNIn) begin
    if (!rstNIn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      mac_sr_q    <= 48'd0;
      type_hi_q   <= 8'd0;
      pay_cnt_q   <= 11'd0;
      payload_q   <= 8'd0;
      pvalid_q    <= 1'b0;
      pstart_q    <= 1'b0;
      plast_q     <= 1'b0;
      etype_q     <= 16'd0;
      src_q       <= 48'd0;
      drop_q      <= 1'b0;
      accept_q    <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mac_sr_q    <= mac_sr_d;
      type_hi_q   <= type_hi_d;
      pay_cnt_q   <= pay_cnt_d;
      payload_q   <= payload_d;
      pvalid_q    <= pvalid_d;
      pstart_q    <= pstart_d;
      plast_q     <= plast_d;
      etype_q     <= etype_d;
      src_q       <= src_d;
      drop_q      <= drop_d;
      accept_q    <= accept_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign payloadOut      = payload_q;
  assign payloadValidOut = pvalid_q;
  assign payloadStartOut = pstart_q;
  assign payloadLastOut  = plast_q;
  assign etherTypeOut    = etype_q;
  assign srcMacOut       = src_q;
  assign frameDropOut    = drop_q;
  assign frameCntOut     = frame_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// tb/tb_eth_rx_frame_parser.sv - scoreboard bench for the Ethernet RX frame parser
module tb_eth_rx_frame_parser;

  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC0      = 48'h00_11_22_33_44_55;
  localparam int          MAX_PRE   = 7;
  localparam int          MIN_PAY   = 46;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_last;
  logic [7:0]  payloadOut;
  logic        payloadValidOut;
  logic        payloadStartOut;
  logic        payloadLastOut;
  logic [15:0] etherTypeOut;
  logic [47:0] srcMacOut;
  logic        frameDropOut;
  logic [15:0] frameCntOut;

  always #2 clk = ~clk;

  eth_rx_frame_parser #(
    .LOCAL_MAC    (LOCAL_MAC),
    .MAX_PREAMBLE (MAX_PRE),
    .MIN_PAYLOAD  (MIN_PAY)
  ) dut (
    .clk250In        (clk),
    .rstNIn          (rst_n),
    .rxDataIn        (rx_data),
    .rxDataValidIn   (rx_valid),
    .rxDataLastIn    (rx_last),
    .payloadOut      (payloadOut),
    .payloadValidOut (payloadValidOut),
    .payloadStartOut (payloadStartOut),
    .payloadLastOut  (payloadLastOut),
    .etherTypeOut    (etherTypeOut),
    .srcMacOut       (srcMacOut),
    .frameDropOut    (frameDropOut),
    .frameCntOut     (frameCntOut)
  );

  typedef struct packed {
    logic [7:0]  data;
    logic        start;
    logic        last;
    logic        drop;
    logic [15:0] et;
    logic [47:0] src;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mb;
  logic [7:0]  frm[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_drops = 0;
  int          obs_drops = 0;
  logic [15:0] exp_cnt = 16'd0;
  bit          mon_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

`ifdef ETH_RX_FCS_CHECK_EN
  // Standard Ethernet FCS over frm[from..to-1]
  function automatic logic [31:0] fcs_of(input int from, input int to);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = from; i < to; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction
`endif

  task automatic build_frame(input int pre, input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] et, input int plen, input bit rnd,
                             input bit corrupt);
    int first_pay;
    frm.delete();
    repeat (pre) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) frm.push_back(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(src[i*8 +: 8]);
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    first_pay = frm.size();
    for (int i = 0; i < plen; i++) frm.push_back(rnd ? 8'($urandom) : 8'(i));
`ifdef ETH_RX_FCS_CHECK_EN
    begin
      logic [31:0] f;
      f = fcs_of(pre + 1, frm.size());
      for (int i = 0; i < 4; i++) frm.push_back(f[i*8 +: 8]);
    end
`endif
    if (corrupt) frm[first_pay] = frm[first_pay] ^ 8'h01;
  endtask

  // Reference model: decide the frame's fate from the byte list as a whole
  task automatic model_frame();
    int          n, k, hs, base, plen;
    bit          ok, bad;
    logic [47:0] dst, src;
    logic [15:0] et;
    beat_t       b;
    n = frm.size();
    k = 0;
    while (k < n && frm[k] == 8'h55) k++;
    ok = (k <= MAX_PRE) && (k < n) && (frm[k] == 8'hD5);
    hs = k + 1;
    ok = ok && (n > hs + 14);
    dst = '0;
    src = '0;
    et  = '0;
    if (ok) begin
      for (int i = 0; i < 6; i++) begin
        dst = {dst[39:0], frm[hs+i]};
        src = {src[39:0], frm[hs+6+i]};
      end
      et = {frm[hs+12], frm[hs+13]};
      ok = (dst == LOCAL_MAC) || (dst == BCAST);
    end
    if (!ok) begin
      exp_drops++;
      return;
    end
    base = hs + 14;
    plen = n - base;
    bad  = plen < MIN_PAY;
`ifdef ETH_RX_FCS_CHECK_EN
    plen = n - base - 4;
    bad  = (plen < MIN_PAY) ||
           (fcs_of(hs, n - 4) != {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
`endif
    for (int i = 0; i < plen; i++) begin
      b.data  = frm[base+i];
      b.start = (i == 0);
      b.last  = (i == plen - 1);
      b.drop  = b.last && bad;
      b.et    = et;
      b.src   = src;
      exp_q.push_back(b);
    end
    if (bad) exp_drops++;
    else exp_cnt++;
  endtask

  task automatic send_frame(input int gap_mode);
    int gaps;
    for (int i = 0; i < frm.size(); i++) begin
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        @(posedge clk); #1;
      end
      rx_data  = frm[i];
      rx_valid = 1'b1;
      rx_last  = (i == frm.size() - 1);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_data  = 8'd0;
  endtask

  task automatic run_frame(input int gap_mode);
    model_frame();
    send_frame(gap_mode);
    repeat (4) @(posedge clk);
    #1;
    check("frame_cnt", 64'(frameCntOut), 64'(exp_cnt));
    check("drop_count", 64'(obs_drops), 64'(exp_drops));
    check("beats_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every payload beat, counts drop pulses
  always @(negedge clk) begin
    if (frameDropOut) obs_drops++;
    if (mon_en && payloadValidOut) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%02h required=none", payloadOut);
      end else begin
        mb = exp_q.pop_front();
        check("beat_data", 64'(payloadOut), 64'(mb.data));
        check("beat_start", 64'(payloadStartOut), 64'(mb.start));
        check("beat_last", 64'(payloadLastOut), 64'(mb.last));
        check("beat_drop", 64'(frameDropOut), 64'(mb.drop));
        check("beat_ethertype", 64'(etherTypeOut), 64'(mb.et));
        check("beat_srcmac", 64'(srcMacOut), 64'(mb.src));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_payload"}, 64'(payloadOut), 64'd0);
    check({tag, "_valid"}, 64'(payloadValidOut), 64'd0);
    check({tag, "_start"}, 64'(payloadStartOut), 64'd0);
    check({tag, "_last"}, 64'(payloadLastOut), 64'd0);
    check({tag, "_ethertype"}, 64'(etherTypeOut), 64'd0);
    check({tag, "_srcmac"}, 64'(srcMacOut), 64'd0);
    check({tag, "_drop"}, 64'(frameDropOut), 64'd0);
    check({tag, "_cnt"}, 64'(frameCntOut), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'd0;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic unicast frame
    build_frame(7, LOCAL_MAC, SRC0, 16'h0800, 46, 1'b0, 1'b0);
    run_frame(0);
    check("first_frame_cnt", 64'(frameCntOut), 64'd1);

    // Foreign destination
    build_frame(7, 48'h02_00_00_00_00_02, SRC0, 16'h0800, 46, 1'b0, 1'b0);
    run_frame(0);

    // Broadcast with valid gaps every other cycle
    build_frame(7, BCAST, SRC0, 16'h0800, 46, 1'b0, 1'b0);
    run_frame(1);

    // Too many preamble bytes
    build_frame(8, LOCAL_MAC, SRC0, 16'h0800, 46, 1'b0, 1'b0);
    run_frame(0);

    // Frame ends on the third source MAC byte
    build_frame(7, LOCAL_MAC, SRC0, 16'h0800, 46, 1'b0, 1'b0);
    while (frm.size() > 17) void'(frm.pop_back());
    run_frame(0);

    // Clean frame afterwards, no preamble at all
    build_frame(0, LOCAL_MAC, 48'hA1_B2_C3_D4_E5_F6, 16'h86DD, 60, 1'b1, 1'b0);
    run_frame(0);

    // Runt and single-byte payload
    build_frame(3, LOCAL_MAC, SRC0, 16'h0806, 10, 1'b1, 1'b0);
    run_frame(0);
    build_frame(7, BCAST, SRC0, 16'h0800, 1, 1'b1, 1'b0);
    run_frame(2);

    // Payload bit flipped after framing
    build_frame(7, LOCAL_MAC, SRC0, 16'h0800, 50, 1'b1, 1'b1);
    run_frame(0);

    // Randomized frames
    for (int t = 0; t < 40; t++) begin
      int          pre, sel, plen, cut;
      logic [47:0] d;
      pre  = $urandom_range(0, 8);
      sel  = $urandom_range(0, 3);
      d    = (sel == 0 || sel == 2) ? LOCAL_MAC : (sel == 1) ? BCAST :
             {16'($urandom), 32'($urandom)};
      plen = $urandom_range(1, 80);
      build_frame(pre, d, {16'($urandom), 32'($urandom)}, 16'($urandom), plen, 1'b1,
                  $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) begin
        cut = $urandom_range(1, frm.size());
        while (frm.size() > cut) void'(frm.pop_back());
      end
      run_frame($urandom_range(0, 2));
    end

    // Reset in the middle of a payload
    build_frame(7, LOCAL_MAC, SRC0, 16'h0800, 46, 1'b0, 1'b0);
    mon_en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rx_data  = frm[i];
      rx_valid = 1'b1;
      rx_last  = 1'b0;
      @(posedge clk); #1;
    end
    check("midframe_valid_before_reset", 64'(payloadValidOut), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    exp_q.delete();
    exp_cnt   = 16'd0;
    exp_drops = 0;
    obs_drops = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    build_frame(7, LOCAL_MAC, SRC0, 16'h0800, 46, 1'b0, 1'b0);
    run_frame(0);
    check("post_reset_cnt", 64'(frameCntOut), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
